// File: rtl/mopshub_sched_pkg.sv
// mopshub_sched_pkg: shared sizes and FSM encoding for the channel mux scheduler
package mopshub_sched_pkg;
  localparam int N_CH = 16;
  localparam int SEL_W = 5;
  localparam int IDX_W = 4;
  typedef enum logic [1:0] {IDLE, LATCH, PRESENT, ACK} state_t;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: rotate-and-priority-encode, first eligible channel after last
module rr_pick16
  import mopshub_sched_pkg::*;
(
  input  logic [N_CH-1:0]  elig,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  // scan from the farthest offset down so the nearest one after last wins
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (elig[last + IDX_W'(i) + 1'b1]) begin
        idx = last + IDX_W'(i) + 1'b1;
        found = 1'b1;
      end
  end
endmodule

// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin control of the registered 16:1 channel mux
module mux16_rr_scheduler
  import mopshub_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_ch,
  output logic [N_CH-1:0]  ack,
  output logic             timeout_err,
  output logic             busy
);
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  state_t state, state_nxt;
  logic [IDX_W-1:0] last, idx;
  logic [CNT_W-1:0] cnt;
  logic found, to_hit;
  rr_pick16 u_pick (.elig(req & ch_mask), .last(last), .idx(idx), .found(found));
  // cnt holds completed PRESENT cycles, so this is the last one allowed
  assign to_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);
  always_comb begin
    state_nxt = state == IDLE    ? (found ? LATCH : IDLE) :
                state == LATCH   ? PRESENT :
                state == PRESENT ? (out_ready ? ACK : to_hit ? IDLE : PRESENT) :
                                   IDLE;
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last <= '1;
      cnt <= '0;
      sel <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
      ack <= '0;
      timeout_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == PRESENT && state_nxt == PRESENT) ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        sel <= {{(SEL_W - IDX_W){1'b0}}, idx};
        out_ch <= idx;
      end
      if (state == PRESENT && state_nxt != PRESENT) last <= out_ch;
      out_valid <= state_nxt == PRESENT;
      ack <= state_nxt == ACK ? N_CH'(1) << out_ch : '0;
      timeout_err <= state == PRESENT && state_nxt == IDLE;
      busy <= state_nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// tb_mux16_rr_scheduler: randomized transaction-level check against a pointer model
module tb_mux16_rr_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] req, ch_mask, ack;
  logic [4:0] sel;
  logic [3:0] out_ch;
  logic out_valid, out_ready, timeout_err, busy;
  int checks = 0;
  int errors = 0;
  int m_last = 15;

  mux16_rr_scheduler #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ch_mask(ch_mask), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .ack(ack), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(int last, logic [15:0] e);
    for (int d = 1; d <= 16; d++)
      if (e[(last + d) % 16]) return (last + d) % 16;
    return -1;
  endfunction

  // Runs one transaction from IDLE and reports what was observed.
  // mode: 0 never ready, 1 always ready, 2 random ready.
  task automatic serve(input int mode, input bit scramble, output int ch, output int pc,
                       output int first_hi, output logic [15:0] ack_v, output bit tmo,
                       output bit ok);
    int n;
    logic [4:0] s;
    logic [3:0] c;
    ok = 1'b1; n = 0; ch = -1; pc = 0; first_hi = -1; ack_v = '0; tmo = 1'b0;
    while (!busy && n < 40) begin
      tick();
      n++;
    end
    if (!busy) begin
      ok = 1'b0;
      return;
    end
    ch = int'(out_ch); s = sel; c = out_ch;
    ok &= (s == {1'b0, c}) && !out_valid && ack == 16'h0 && !timeout_err;
    if (scramble) begin
      req = 16'($urandom);
      ch_mask = 16'($urandom);
    end
    out_ready = 1'b0;
    tick();
    n = 0;
    while (out_valid && n < 300) begin
      ok &= sel == s && out_ch == c && ack == 16'h0 && !timeout_err && busy;
      out_ready = mode == 1 ? 1'b1 : mode == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      if (out_ready && first_hi < 0) first_hi = pc;
      pc++; n++;
      tick();
    end
    out_ready = 1'b0;
    ack_v = ack; tmo = timeout_err;
    ok &= !out_valid && pc > 0;
    if (ack_v != 16'h0) begin
      tick();
      ok &= ack == 16'h0 && !timeout_err && !busy;
    end
  endtask

  task automatic test_reset();
    int ch, pc, fh;
    logic [15:0] av;
    bit tmo, ok;
    rst = 1'b0; req = '0; ch_mask = '0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({sel, out_valid, out_ch, ack, timeout_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values sel=%h v=%b ch=%h ack=%h to=%b busy=%b required all 0",
               sel, out_valid, out_ch, ack, timeout_err, busy);
    end
    rst = 1'b1; req = 16'h0008; ch_mask = 16'hFFFF;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_present valid=%b ch=%0d required 1/3", out_valid, out_ch);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sel, out_valid, out_ch, ack, timeout_err, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset sel=%h v=%b ch=%h ack=%h to=%b busy=%b required all 0",
               sel, out_valid, out_ch, ack, timeout_err, busy);
    end
    @(negedge clk);
    rst = 1'b1; m_last = 15;
    serve(1, 1'b0, ch, pc, fh, av, tmo, ok);
    checks++;
    if (ch != pick(m_last, 16'h0008) || av !== 16'h0008 || !ok) begin
      errors++;
      $display("FAIL reset_regrant ch=%0d ack=%h ok=%b required ch=3 ack=0008 ok=1", ch, av, ok);
    end
    m_last = 3;
    req = '0;
  endtask

  task automatic test_single();
    req = 16'h0001; ch_mask = 16'hFFFF; out_ready = 1'b1;
    tick();
    checks++;
    if (sel !== 5'd0 || out_ch !== 4'd0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant sel=%0d ch=%0d busy=%b v=%b required 0/0/1/0",
               sel, out_ch, busy, out_valid);
    end
    req = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid got=%b required 1", out_valid);
    end
    tick();
    checks++;
    if (ack !== 16'h0001 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack ack=%h v=%b required 0001/0", ack, out_valid);
    end
    tick();
    checks++;
    if (ack !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done ack=%h busy=%b required 0000/0", ack, busy);
    end
    out_ready = 1'b0;
    m_last = 0;
  endtask

  task automatic test_round_robin();
    int ch, pc, fh, exp;
    logic [15:0] av;
    bit tmo, ok;
    for (int i = 0; i < 6; i++) begin
      req = 16'h8001; ch_mask = 16'hFFFF;
      exp = pick(m_last, req & ch_mask);
      serve(1, 1'b0, ch, pc, fh, av, tmo, ok);
      checks++;
      if (ch != exp || av !== 16'(1) << exp || pc != 1 || !ok) begin
        errors++;
        $display("FAIL rr_order[%0d] ch=%0d ack=%h pc=%0d ok=%b required ch=%0d pc=1",
                 i, ch, av, pc, ok, exp);
      end
      m_last = exp;
    end
  endtask

  task automatic test_masking();
    int ch, pc, fh, exp;
    logic [15:0] av;
    bit tmo, ok;
    for (int i = 0; i < 5; i++) begin
      req = 16'hFFFF; ch_mask = 16'h0F00;
      exp = pick(m_last, req & ch_mask);
      serve(1, 1'b0, ch, pc, fh, av, tmo, ok);
      checks++;
      if (ch != exp || ch < 8 || ch > 11 || av !== 16'(1) << exp || !ok) begin
        errors++;
        $display("FAIL mask_order[%0d] ch=%0d ack=%h ok=%b required ch=%0d", i, ch, av, ok, exp);
      end
      m_last = exp;
    end
  endtask

  task automatic test_timeout();
    int ch, pc, fh, exp, first;
    logic [15:0] av;
    bit tmo, ok;
    req = 16'h0030; ch_mask = 16'hFFFF;
    exp = pick(m_last, req);
    serve(0, 1'b0, ch, pc, fh, av, tmo, ok);
    checks++;
    if (ch != exp || pc != 4 || tmo !== 1'b1 || av !== 16'h0 || !ok) begin
      errors++;
      $display("FAIL timeout ch=%0d pc=%0d to=%b ack=%h ok=%b required ch=%0d pc=4 to=1 ack=0",
               ch, pc, tmo, av, ok, exp);
    end
    first = exp;
    m_last = exp;
    exp = pick(m_last, req);
    serve(1, 1'b0, ch, pc, fh, av, tmo, ok);
    checks++;
    if (ch != exp || ch == first || av !== 16'(1) << exp || !ok) begin
      errors++;
      $display("FAIL timeout_advance ch=%0d ack=%h ok=%b required ch=%0d", ch, av, ok, exp);
    end
    m_last = exp;
  endtask

  task automatic test_random();
    int ch, pc, fh, exp, b;
    logic [15:0] av;
    bit tmo, ok, scr;
    for (int i = 0; i < 30; i++) begin
      req = 16'($urandom); ch_mask = 16'($urandom);
      if ((req & ch_mask) == 16'h0) begin
        b = int'($urandom_range(0, 15));
        req[b] = 1'b1; ch_mask[b] = 1'b1;
      end
      exp = pick(m_last, req & ch_mask);
      scr = 1'($urandom_range(0, 1));
      serve(2, scr, ch, pc, fh, av, tmo, ok);
      checks++;
      if (fh >= 0 && fh < 4) begin
        if (ch != exp || pc != fh + 1 || av !== 16'(1) << exp || tmo || !ok) begin
          errors++;
          $display("FAIL rand_xfer[%0d] ch=%0d pc=%0d ack=%h to=%b ok=%b required ch=%0d pc=%0d",
                   i, ch, pc, av, tmo, ok, exp, fh + 1);
        end
      end else if (ch != exp || pc != 4 || av !== 16'h0 || !tmo || !ok) begin
        errors++;
        $display("FAIL rand_timeout[%0d] ch=%0d pc=%0d ack=%h to=%b ok=%b required ch=%0d pc=4",
                 i, ch, pc, av, tmo, ok, exp);
      end
      m_last = exp;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
